// File: rtl/reg_file_if.sv
// rtl/reg_file_if.sv - bus bundle between a register-file user and reg_file
// Ports carried:
//   we, wa, wd       write port (enable, address, data)
//   ra1, ra2         read addresses
//   rd1, rd2         read data
//   bset, bset_a     mark a register pending (result outstanding)
//   busy1, busy2     pending flags for ra1/ra2
//   stall            busy1 | busy2
// master drives requests and reads results; slave is the register file.
interface reg_file_if #(
    parameter int N     = 8,
    parameter int DEPTH = 32
);
    localparam int AW = $clog2(DEPTH);

    logic          we;
    logic [AW-1:0] wa;
    logic [N-1:0]  wd;
    logic [AW-1:0] ra1;
    logic [AW-1:0] ra2;
    logic [N-1:0]  rd1;
    logic [N-1:0]  rd2;
    logic          bset;
    logic [AW-1:0] bset_a;
    logic          busy1;
    logic          busy2;
    logic          stall;

    modport master (
        output we, wa, wd, ra1, ra2, bset, bset_a,
        input  rd1, rd2, busy1, busy2, stall
    );

    modport slave (
        input  we, wa, wd, ra1, ra2, bset, bset_a,
        output rd1, rd2, busy1, busy2, stall
    );
endinterface

// File: rtl/reg_file.sv
// rtl/reg_file.sv - two-read one-write register file with per-register pending scoreboard
// Ports:
//   clk      rising-edge clock for all state
//   n_reset  asynchronous active-low reset; clears data and pending bits
//   bus      reg_file_if slave modport (write port, two read ports,
//            pending-set port, busy/stall outputs)
// Register 0 is hardwired to zero and can never be marked pending.
// Addresses at or above DEPTH read zero, are never busy, and ignore writes.
module reg_file #(
    parameter int N     = 8,
    parameter int DEPTH = 32
) (
    input logic         clk,
    input logic         n_reset,
    reg_file_if.slave   bus
);
    localparam int AW   = $clog2(DEPTH);
    localparam bit POW2 = (DEPTH == (1 << AW));

    logic [N-1:0]     mem [DEPTH];
    logic [DEPTH-1:0] busy;

    logic wr_ok;
    logic bset_ok;

    // True when the address names a writable register (non-zero, implemented).
    function automatic logic usable(input logic [AW-1:0] a);
        return (a != '0) && (POW2 || (32'(a) < DEPTH));
    endfunction

    assign wr_ok   = bus.we   && usable(bus.wa);
    assign bset_ok = bus.bset && usable(bus.bset_a);

    // The pending set is applied after the write's clear so that a new issue
    // landing on the same edge as the old result leaves the register pending.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            busy <= '0;
        end else begin
            if (wr_ok) begin
                mem[bus.wa]  <= bus.wd;
                busy[bus.wa] <= 1'b0;
            end
            if (bset_ok) begin
                busy[bus.bset_a] <= 1'b1;
            end
        end
    end

    // Combinational read with write-first bypass. The bypass is kept live
    // during reset so a producer's result is visible the moment it is driven.
    // A write in flight to the read address also hides the pending flag,
    // matching the data the bypass is already returning.
    always_comb begin
        bus.rd1   = '0;
        bus.rd2   = '0;
        bus.busy1 = 1'b0;
        bus.busy2 = 1'b0;

        if (usable(bus.ra1)) begin
            if (bus.we && bus.wa == bus.ra1) begin
                bus.rd1 = bus.wd;
            end else begin
                bus.rd1   = mem[bus.ra1];
                bus.busy1 = busy[bus.ra1];
            end
        end

        if (usable(bus.ra2)) begin
            if (bus.we && bus.wa == bus.ra2) begin
                bus.rd2 = bus.wd;
            end else begin
                bus.rd2   = mem[bus.ra2];
                bus.busy2 = busy[bus.ra2];
            end
        end

        bus.stall = bus.busy1 | bus.busy2;
    end
endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - scoreboard testbench for reg_file
module tb_reg_file;
    localparam int N     = 8;
    localparam int DEPTH = 32;

    logic clk;
    logic n_reset;

    reg_file_if #(.N(N), .DEPTH(DEPTH)) bus ();

    reg_file #(.N(N), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .n_reset (n_reset),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [N-1:0] rd1;
        logic [N-1:0] rd2;
        logic         b1;
        logic         b2;
    } exp_t;

    exp_t q[$];
    event sample_ev;
    int   n_checks = 0;
    int   n_fail   = 0;

    // Push an expectation, let combinational paths settle, then tell the
    // monitor to compare what the DUT presents against the queue head.
    task automatic expect_out(input string name, input logic [N-1:0] e1,
                              input logic [N-1:0] e2, input logic b1, input logic b2);
        exp_t e;
        e.name = name; e.rd1 = e1; e.rd2 = e2; e.b1 = b1; e.b2 = b2;
        q.push_back(e);
        #1;
        ->sample_ev;
        #0;
    endtask

    task automatic cmp(input string name, input string field,
                       input logic [N-1:0] got, input logic [N-1:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s %s: got %0d expected %0d", name, field, got, want);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(sample_ev);
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL monitor: sample with empty queue got 0 expected 1 entries");
            end else begin
                e = q.pop_front();
                cmp(e.name, "rd1",   bus.rd1,        e.rd1);
                cmp(e.name, "rd2",   bus.rd2,        e.rd2);
                cmp(e.name, "busy1", N'(bus.busy1),  N'(e.b1));
                cmp(e.name, "busy2", N'(bus.busy2),  N'(e.b2));
                cmp(e.name, "stall", N'(bus.stall),  N'(e.b1 | e.b2));
            end
        end
    end

    task automatic idle();
        bus.we = 1'b0; bus.wa = '0; bus.wd = '0;
        bus.bset = 1'b0; bus.bset_a = '0;
    endtask

    initial begin : watchdog
        #20000;
        $display("FAIL watchdog: time limit got expired expected finished");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : stim
        n_reset = 1'b0;
        idle();
        bus.ra1 = 5'd5; bus.ra2 = 5'd31;
        #2;
        expect_out("in_reset", 8'd0, 8'd0, 1'b0, 1'b0);

        @(negedge clk);
        n_reset = 1'b1;
        @(negedge clk);
        expect_out("after_reset", 8'd0, 8'd0, 1'b0, 1'b0);

        // Bypass, then value held after the edge.
        bus.we = 1'b1; bus.wa = 5'd3; bus.wd = 8'd133; bus.ra1 = 5'd3;
        expect_out("bypass3", 8'd133, 8'd0, 1'b0, 1'b0);
        @(negedge clk);
        idle();
        expect_out("held3", 8'd133, 8'd0, 1'b0, 1'b0);

        // Register 0 ignores writes and bset.
        bus.we = 1'b1; bus.wa = 5'd0; bus.wd = 8'd222; bus.ra1 = 5'd0;
        expect_out("r0_wr_bypass", 8'd0, 8'd0, 1'b0, 1'b0);
        @(negedge clk);
        idle();
        bus.bset = 1'b1; bus.bset_a = 5'd0;
        expect_out("r0_read", 8'd0, 8'd0, 1'b0, 1'b0);
        @(negedge clk);
        idle();
        expect_out("r0_not_busy", 8'd0, 8'd0, 1'b0, 1'b0);

        // Pending set, then cleared by a write in flight.
        bus.bset = 1'b1; bus.bset_a = 5'd7;
        @(negedge clk);
        idle();
        bus.ra1 = 5'd3; bus.ra2 = 5'd7;
        expect_out("r7_busy", 8'd133, 8'd0, 1'b0, 1'b1);
        bus.we = 1'b1; bus.wa = 5'd7; bus.wd = 8'd54;
        expect_out("r7_wr_inflight", 8'd133, 8'd54, 1'b0, 1'b0);
        @(negedge clk);
        idle();
        expect_out("r7_cleared", 8'd133, 8'd54, 1'b0, 1'b0);

        // Double bset stays busy; both ports on the same address agree.
        bus.bset = 1'b1; bus.bset_a = 5'd7;
        @(negedge clk);
        @(negedge clk);
        idle();
        bus.ra1 = 5'd7; bus.ra2 = 5'd7;
        expect_out("r7_twice_same", 8'd54, 8'd54, 1'b1, 1'b1);
        bus.we = 1'b1; bus.wa = 5'd7; bus.wd = 8'd60;
        @(negedge clk);
        idle();
        expect_out("r7_rewritten", 8'd60, 8'd60, 1'b0, 1'b0);

        // Same-edge bset and write: data lands, pending wins.
        bus.bset = 1'b1; bus.bset_a = 5'd9;
        bus.we = 1'b1; bus.wa = 5'd9; bus.wd = 8'd99;
        @(negedge clk);
        idle();
        bus.ra1 = 5'd9; bus.ra2 = 5'd3;
        expect_out("r9_same_edge", 8'd99, 8'd133, 1'b1, 1'b0);

        // Plain write to a non-busy register, top address.
        bus.we = 1'b1; bus.wa = 5'd31; bus.wd = 8'hA5;
        @(negedge clk);
        idle();
        bus.ra1 = 5'd31; bus.ra2 = 5'd9;
        expect_out("r31_write", 8'hA5, 8'd99, 1'b0, 1'b1);

        // Mid-cycle asynchronous reset.
        bus.we = 1'b1; bus.wa = 5'd4; bus.wd = 8'd54;
        bus.bset = 1'b1; bus.bset_a = 5'd6;
        @(negedge clk);
        idle();
        bus.ra1 = 5'd4; bus.ra2 = 5'd6;
        expect_out("pre_reset", 8'd54, 8'd0, 1'b0, 1'b1);
        n_reset = 1'b0;
        expect_out("async_reset", 8'd0, 8'd0, 1'b0, 1'b0);
        bus.we = 1'b1; bus.wa = 5'd5; bus.wd = 8'd77; bus.bset = 1'b1; bus.bset_a = 5'd9;
        bus.ra1 = 5'd5; bus.ra2 = 5'd9;
        expect_out("reset_bypass", 8'd77, 8'd0, 1'b0, 1'b0);
        @(negedge clk);
        idle();
        n_reset = 1'b1;
        expect_out("reset_blocked", 8'd0, 8'd0, 1'b0, 1'b0);
        bus.ra1 = 5'd31; bus.ra2 = 5'd7;
        expect_out("reset_cleared", 8'd0, 8'd0, 1'b0, 1'b0);

        @(negedge clk);
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain: got %0d expected 0 entries", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
